// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and data memory.
// Hits complete combinationally; misses stall the pipeline through optional write-back and refill.
module dcache_ctrl #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WRD_W = OFF_W - 2;
  localparam int BIT_W = $clog2(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_arr_q  [LINES];
  logic [LINE_W-1:0] data_arr_q [LINES];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WRD_W-1:0]  req_word;
  logic [BIT_W-1:0]  word_lsb;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic              req, is_read, is_write, hit;
  logic              line_we, tag_we;
  logic [LINE_W-1:0] line_wdata;
  logic              unused_addr_bits;

  assign req_tag          = p1_addr_i[31 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign req_word         = p1_addr_i[2 +: WRD_W];
  assign word_lsb         = {req_word, 5'd0};
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign line_tag  = tag_arr_q[req_idx];
  assign line_data = data_arr_q[req_idx];

  // A store wins when both request strobes are high.
  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign is_write = p1_MemWrite_i;
  assign is_read  = p1_MemRead_i & ~p1_MemWrite_i;
  assign hit      = valid_q[req_idx] && (line_tag == req_tag);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = line_data;
    p1_data_o    = '0;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          if (is_read) p1_data_o = line_data[word_lsb +: 32];
          if (is_write) begin
            line_we                     = 1'b1;
            line_wdata[word_lsb +: 32]  = p1_data_i;
            dirty_d[req_idx]            = 1'b1;
          end
        end else if (req) begin
          p1_stall_o = 1'b1;
          state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        p1_stall_o   = req;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, req_idx, {OFF_W{1'b0}}};
        mem_data_o   = line_data;
        if (mem_ack_i) state_d = S_ALLOCATE;
      end

      S_ALLOCATE: begin
        p1_stall_o   = req;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          line_we          = 1'b1;
          tag_we           = 1'b1;
          line_wdata       = mem_data_i;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // While reset is held the cleared valid bits would look like a miss; keep the pipeline free.
    if (rst_i) p1_stall_o = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays are deliberately left unreset; the valid bits guard them, so they can map to RAM.
  always_ff @(posedge clk_i) begin
    if (line_we) data_arr_q[req_idx] <= line_wdata;
    if (tag_we)  tag_arr_q[req_idx]  <= req_tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a latency-programmable memory model plus
// scoreboards of expected CPU-side results and expected memory transfers.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          stalls;
    logic [31:0] rdata;
  } acc_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } tx_t;

  acc_t         exp_acc_q[$];
  tx_t          exp_tx_q[$];
  logic [255:0] mem_lines [logic [31:0]];
  int           lat = 3;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [255:0] default_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'h5A00_0000 + a + 32'(4 * w);
    return l;
  endfunction

  function automatic logic [255:0] read_line(input logic [31:0] a);
    if (mem_lines.exists(a)) return mem_lines[a];
    return default_line(a);
  endfunction

  function automatic logic [31:0] word0_of(input logic [31:0] a);
    logic [255:0] l;
    l = read_line(a);
    return l[31:0];
  endfunction

  // Memory model: acks in the lat-th enable cycle, checks each transfer against the expected queue.
  int           cnt = 0;
  logic         cur_we;
  logic [31:0]  cur_addr;
  logic [255:0] cur_data;
  bit           cur_stable;
  tx_t          et;

  always @(negedge clk_i) begin
    if (rst_i) begin
      cnt       = 0;
      mem_ack_i = 1'b0;
    end else begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt       = 0;
      end
      if (mem_enable_o) begin
        if (cnt == 0) begin
          cur_we     = mem_write_o;
          cur_addr   = mem_addr_o;
          cur_data   = mem_write_o ? mem_data_o : '0;
          cur_stable = 1'b1;
        end else if (mem_write_o !== cur_we || mem_addr_o !== cur_addr ||
                     (cur_we && mem_data_o !== cur_data)) begin
          cur_stable = 1'b0;
        end
        cnt++;
        if (cnt == lat) begin
          mem_ack_i = 1'b1;
          if (cur_we) mem_lines[cur_addr] = cur_data;
          else        mem_data_i = read_line(cur_addr);
          checks++;
          if (exp_tx_q.size() == 0) begin
            errors++;
            $display("FAIL mem_tx unexpected: we=%0b addr=%h", cur_we, cur_addr);
          end else begin
            et = exp_tx_q.pop_front();
            if (cur_we !== et.we || cur_addr !== et.addr || (cur_we && cur_data !== et.data) || !cur_stable) begin
              errors++;
              $display("FAIL mem_tx: got we=%0b addr=%h stable=%0b data=%h, want we=%0b addr=%h data=%h",
                       cur_we, cur_addr, cur_stable, cur_data, et.we, et.addr, et.data);
            end
          end
        end
      end
    end
  end

  // Drives one CPU access and holds it until the stall drops; result is popped from the scoreboard.
  task automatic access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd, input logic wr, input int exp_stalls, input logic [31:0] exp_rdata);
    acc_t        e;
    int          stalls;
    logic [31:0] got;
    e = '{name, exp_stalls, exp_rdata};
    exp_acc_q.push_back(e);
    @(negedge clk_i);
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    stalls = 0;
    #1;
    while (p1_stall_o === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    got = p1_data_o;
    e   = exp_acc_q.pop_front();
    checks++;
    if (stalls >= 100) begin
      errors++;
      $display("FAIL %s: stall never released within 100 cycles", e.name);
    end else if (stalls != e.stalls || got !== e.rdata) begin
      errors++;
      $display("FAIL %s: got stalls=%0d data=%h, want stalls=%0d data=%h", e.name, stalls, got, e.stalls, e.rdata);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    p1_addr_i    = 32'h40;
    p1_MemRead_i = 1'b1;
    #1;
    checks++;
    if ({p1_stall_o, mem_enable_o, mem_write_o} !== 3'b000 || mem_addr_o !== 32'h0 || p1_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b en=%b wr=%b addr=%h data=%h, want all 0",
               p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p1_data_o);
    end
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_data_o !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: stall=%b en=%b, want 0 0", p1_stall_o, mem_enable_o);
    end
  endtask

  task automatic test_clean_miss();
    lat = 3;
    exp_tx_q.push_back('{1'b0, 32'h40, '0});
    access("load_40_miss", 32'h40, 32'h0, 1'b1, 1'b0, 4, 32'h0A0B_0C0D);
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL clean_miss_tx: %0d transfers outstanding, want 0", exp_tx_q.size());
    end
  endtask

  task automatic test_read_hit();
    access("load_44_hit", 32'h44, 32'h0, 1'b1, 1'b0, 0, 32'h1111_2222);
  endtask

  task automatic test_write_hit();
    access("store_44_hit", 32'h44, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 32'h0);
    access("load_44_after_store", 32'h44, 32'h0, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_dirty_miss();
    logic [255:0] wb;
    lat = 3;
    wb = read_line(32'h40);
    wb[63:32] = 32'hDEAD_BEEF;
    exp_tx_q.push_back('{1'b1, 32'h40, wb});
    exp_tx_q.push_back('{1'b0, 32'h440, '0});
    access("load_440_dirty_miss", 32'h440, 32'h0, 1'b1, 1'b0, 7, word0_of(32'h440));
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL dirty_miss_tx: %0d transfers outstanding, want 0", exp_tx_q.size());
    end
  endtask

  task automatic test_reset_mid_alloc();
    lat = 3;
    @(negedge clk_i);
    p1_addr_i     = 32'h80;
    p1_MemRead_i  = 1'b1;
    p1_MemWrite_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h80 || p1_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL alloc_80: en=%b wr=%b addr=%h stall=%b, want 1 0 00000080 1",
               mem_enable_o, mem_write_o, mem_addr_o, p1_stall_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_alloc: en=%b stall=%b addr=%h, want 0 0 00000000", mem_enable_o, p1_stall_o, mem_addr_o);
    end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    // Line 0x40 was written back earlier, so its refill carries the stored word.
    exp_tx_q.push_back('{1'b0, 32'h40, '0});
    access("load_40_after_reset", 32'h40, 32'h0, 1'b1, 1'b0, 4, 32'h0A0B_0C0D);
    access("load_44_refetched", 32'h44, 32'h0, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_store_alloc();
    logic [255:0] wb;
    lat = 2;
    exp_tx_q.push_back('{1'b0, 32'h800, '0});
    access("store_800_miss", 32'h800, 32'h0000_00AA, 1'b0, 1'b1, 3, 32'h0);
    wb = read_line(32'h800);
    wb[31:0] = 32'h0000_00AA;
    exp_tx_q.push_back('{1'b1, 32'h800, wb});
    exp_tx_q.push_back('{1'b0, 32'hC00, '0});
    access("load_C00_evicts_800", 32'hC00, 32'h0, 1'b1, 1'b0, 5, word0_of(32'hC00));
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL store_alloc_tx: %0d transfers outstanding, want 0", exp_tx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wb;
    lat = 1;
    exp_tx_q.push_back('{1'b0, 32'h1000, '0});
    access("load_1000_n1", 32'h1000, 32'h0, 1'b1, 1'b0, 2, word0_of(32'h1000));
    access("store_1004_hit", 32'h1004, 32'h1234_5678, 1'b0, 1'b1, 0, 32'h0);
    access("load_1004_hit", 32'h1004, 32'h0, 1'b1, 1'b0, 0, 32'h1234_5678);
    wb = read_line(32'h1000);
    wb[63:32] = 32'h1234_5678;
    exp_tx_q.push_back('{1'b1, 32'h1000, wb});
    exp_tx_q.push_back('{1'b0, 32'h1400, '0});
    access("load_1400_alias_n1", 32'h1400, 32'h0, 1'b1, 1'b0, 3, word0_of(32'h1400));
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_tx: %0d transfers outstanding, want 0", exp_tx_q.size());
    end
  endtask

  initial begin
    logic [255:0] l;
    l = default_line(32'h40);
    l[31:0]  = 32'h0A0B_0C0D;
    l[63:32] = 32'h1111_2222;
    mem_lines[32'h40] = l;

    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_reset_mid_alloc();
    test_store_alloc();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
